imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the decode stage. Takes the instruction word plus its ImmType selector and produces an XLEN-wide immediate.
- Adds two formats beyond the basic five: ZTYPE (CSR uimm) and SHTYPE (shift amount).
- A 2-entry skid buffer lets the decode stage stall or flush without dropping instructions.
- Carries a PC/tag sideband aligned with each immediate.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediate sign/zero-extended to XLEN.
TAG_W, 32, width of sideband tag (normally PC) carried alongside each immediate.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous; discards all buffered entries.
in_valid  input  1  instruction/type valid.
in_ready  output  1  block can accept an entry this cycle.
in_inst  input  32  instruction word (bits 6:0 ignored).
in_type  input  3  ImmType code.
in_tag  input  TAG_W  sideband, returned unchanged.
out_valid  output  1  out_imm/out_tag/out_err valid.
out_ready  input  1  consumer accepts the entry.
out_imm  output  XLEN  generated immediate.
out_tag  output  TAG_W  tag of the entry.
out_err  output  1  SHTYPE shamt illegal for XLEN.

Behaviour:
- ImmType codes; S(x) means sign-extend x to XLEN:
  - 0 RTYPE: 0.
  - 1 ITYPE: S(inst[31:20]).
  - 2 STYPE: S({inst[31:25],inst[11:7]}).
  - 3 BTYPE: S({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 4 UTYPE: S({inst[31:12],12'b0}); upper bits are the sign copy of inst[31] when XLEN=64.
  - 5 JTYPE: S({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 6 ZTYPE: zero-extend inst[19:15].
  - 7 SHTYPE: zero-extend inst[25:20] when XLEN=64, inst[24:20] when XLEN=32.
- out_err = 1 only for SHTYPE with XLEN=32 and inst[25]=1; out_imm is still the 5-bit shamt. out_err = 0 for all other types.
- Immediate computed combinationally at input; written into the buffer on accept.
- Buffer: 2-entry FIFO, with head and tail pointers and a count of 0..2. The head entry drives the outputs directly from registers.
- in_ready = (count < 2); registered, not dependent on out_ready.
- out_valid = (count != 0).
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- Simultaneous accept and pop: count is unchanged and pointers advance. At count=1 the new entry lands behind the head, so ordering is preserved.
- Latency: entry accepted in cycle N appears on out_valid in cycle N+1 at the earliest.
- Throughput: 1 entry/cycle while out_ready stays high.
- Stall: while out_ready=0, the head entry's outputs stay stable. A second entry can still be accepted; then in_ready drops.
- Outputs are held stable while out_valid & !out_ready (AXI-style; a bench assertion checks this).
- flush: the next edge clears count and pointers; any accept in the flush cycle is dropped; out_valid=0 in the following cycle. flush takes priority over accept and pop.
- Reset (rst_n low, asynchronous):
  - count=0, pointers=0, out_valid=0.
  - out_imm=0, out_tag=0, out_err=0.
  - in_ready=1 once reset is released.
- Reset asserted mid-stream discards all entries immediately.
- Storage registers beyond the head need no reset, but outputs must read 0 while empty after reset.

Test Plan:
- ITYPE: in_inst=0xFFF00093 (addi x1,x0,-1), XLEN=32 -> out_imm=0xFFFFFFFF one cycle later; XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- STYPE/BTYPE: 0xFE112E23 -> 0xFFFFFFFC; 0xFE000CE3 -> 0xFFFFFFF8; both with out_err=0.
- UTYPE/ZTYPE/SHTYPE:
  - UTYPE 0x12345037 -> 0x12345000.
  - ZTYPE with inst[19:15]=0x1F -> 0x0000001F.
  - SHTYPE with inst[25:20]=0x21: XLEN=32 -> out_imm=0x01 with out_err=1; XLEN=64 -> out_imm=0x21 with out_err=0.
- Backpressure: out_ready=0 while 3 entries are offered back-to-back:
  - Only 2 are accepted; in_ready=0 on the third cycle.
  - Head outputs stay stable.
  - Releasing out_ready delivers both entries in order with the correct tags.
- Simultaneous push/pop at count=1 for 8 cycles -> count stays 1 and the tag sequence is preserved in order.
- flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed input never appears at the output. Async reset mid-stream -> out_valid=0 and out_imm=0 immediately.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a 2-entry skid FIFO.
// Immediates are formed at the input and carried with a tag to the output.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef enum logic [2:0] {
        RTYPE  = 3'd0,
        ITYPE  = 3'd1,
        STYPE  = 3'd2,
        BTYPE  = 3'd3,
        UTYPE  = 3'd4,
        JTYPE  = 3'd5,
        ZTYPE  = 3'd6,
        SHTYPE = 3'd7
    } imm_type_e;

    logic [XLEN-1:0]  imm_d;
    logic             err_d;
    logic             unused_opcode;

    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             err_q [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             accept, pop, wr_en;

    assign unused_opcode = ^in_inst[6:0];

    always_comb begin
        imm_d = '0;
        err_d = 1'b0;
        unique case (imm_type_e'(in_type))
            RTYPE: imm_d = '0;
            ITYPE: imm_d = XLEN'($signed(in_inst[31:20]));
            STYPE: imm_d = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            BTYPE: imm_d = XLEN'($signed({in_inst[31], in_inst[7],
                                          in_inst[30:25], in_inst[11:8],
                                          1'b0}));
            UTYPE: imm_d = XLEN'($signed({in_inst[31:12], 12'b0}));
            JTYPE: imm_d = XLEN'($signed({in_inst[31], in_inst[19:12],
                                          in_inst[20], in_inst[30:21],
                                          1'b0}));
            ZTYPE: imm_d = XLEN'(in_inst[19:15]);
            SHTYPE: begin
                if (XLEN == 64) begin
                    imm_d = XLEN'(in_inst[25:20]);
                end else begin
                    // shamt bit 5 is illegal on RV32; keep the low 5 bits
                    imm_d = XLEN'(in_inst[24:20]);
                    err_d = in_inst[25];
                end
            end
        endcase
    end

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = accept & ~flush;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush) begin
            head_d = 1'b0;
            tail_d = 1'b0;
            cnt_d  = 2'd0;
        end else begin
            if (accept) tail_d = ~tail_q;
            if (pop)    head_d = ~head_q;
            cnt_d = cnt_q + {1'b0, accept} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Cleared on reset so the empty head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            imm_q[tail_q] <= imm_d;
            tag_q[tail_q] <= in_tag;
            err_q[tail_q] <= err_d;
        end
    end

    assign out_imm = imm_q[head_q];
    assign out_tag = tag_q[head_q];
    assign out_err = err_q[head_q];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe; runs XLEN=32 and XLEN=64 side by side.
// Random traffic is scored against a queue model built from the format rules.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_tag;
    logic [2:0]  in_type;
    logic        in_ready32, in_ready64, out_valid32, out_valid64;
    logic [31:0] out_imm32, out_tag32, out_tag64;
    logic [63:0] out_imm64;
    logic        out_err32, out_err64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic        err32;
        logic [31:0] tag;
    } exp_t;

    function automatic logic [63:0] ref_imm(input logic [31:0] inst,
                                            input logic [2:0] t,
                                            input int xlen);
        longint v;
        logic [63:0] r;
        v = 0;
        case (t)
            3'd1: begin v = inst[31:20]; if (v >= 2048) v -= 4096; end
            3'd2: begin
                v = {inst[31:25], inst[11:7]};
                if (v >= 2048) v -= 4096;
            end
            3'd3: begin
                v = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                if (v >= 4096) v -= 8192;
            end
            3'd4: begin
                v = inst[31:12];
                v = v * 4096;
                if (inst[31]) v -= 64'sd4294967296;
            end
            3'd5: begin
                v = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                if (v >= 1048576) v -= 2097152;
            end
            3'd6: v = inst[19:15];
            3'd7: v = (xlen == 64) ? longint'(inst[25:20])
                                   : longint'(inst[24:20]);
            default: v = 0;
        endcase
        r = v;
        if (xlen == 32) r = {32'b0, r[31:0]};
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] inst,
                                    input logic [2:0] t,
                                    input logic [31:0] tag);
        exp_t e;
        logic [63:0] r32;
        r32     = ref_imm(inst, t, 32);
        e.imm32 = r32[31:0];
        e.imm64 = ref_imm(inst, t, 64);
        e.err32 = (t == 3'd7) && inst[25];
        e.tag   = tag;
        return e;
    endfunction

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_type = '0; in_tag = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #12;
        checks++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b/%b exp 0", out_valid32, out_valid64);
        end
        checks++;
        if (out_imm32 !== 32'h0 || out_imm64 !== 64'h0 || out_tag32 !== 32'h0
            || out_err32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got imm %h/%h tag %h err %b exp 0",
                     out_imm32, out_imm64, out_tag32, out_err32);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b/%b exp 1", in_ready32, in_ready64);
        end
    endtask

    task automatic test_formats();
        logic [31:0] vi[7]  = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3,
                                32'h12345037, 32'h000F8073, 32'h02100013,
                                32'hFFFFFFB3};
        logic [2:0]  vt[7]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0};
        logic [31:0] e32[7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                32'h12345000, 32'h0000001F, 32'h00000001,
                                32'h0};
        logic [63:0] e64[7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                64'hFFFFFFFFFFFFFFF8, 64'h12345000,
                                64'h1F, 64'h21, 64'h0};
        logic        er[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            in_inst = vi[i]; in_type = vt[i]; in_tag = 32'(100 + i);
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid32 !== 1'b1 || out_imm32 !== e32[i]
                || out_err32 !== er[i] || out_tag32 !== 32'(100 + i)) begin
                errors++;
                $display("FAIL fmt32[%0d] got v%b imm %h err %b tag %h exp imm %h err %b",
                         i, out_valid32, out_imm32, out_err32, out_tag32,
                         e32[i], er[i]);
            end
            checks++;
            if (out_valid64 !== 1'b1 || out_imm64 !== e64[i]
                || out_err64 !== 1'b0 || out_tag64 !== 32'(100 + i)) begin
                errors++;
                $display("FAIL fmt64[%0d] got v%b imm %h err %b tag %h exp imm %h err 0",
                         i, out_valid64, out_imm64, out_err64, out_tag64, e64[i]);
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_backpressure();
        logic [31:0] ta, tb, tc, ia;
        exp_t ea;
        ta = $urandom; tb = $urandom; tc = $urandom; ia = $urandom;
        ea = mk_exp(ia, 3'd1, ta);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_type = 3'd1;
        in_inst = ia; in_tag = ta;
        checks++;
        if (in_ready32 !== 1'b1) begin
            errors++; $display("FAIL bp_ready0 got %b exp 1", in_ready32);
        end
        @(posedge clk); #1;
        in_inst = $urandom; in_tag = tb;
        checks++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b1 || out_tag32 !== ta) begin
            errors++;
            $display("FAIL bp_first got rdy %b v %b tag %h exp 1 1 %h",
                     in_ready32, out_valid32, out_tag32, ta);
        end
        @(posedge clk); #1;
        in_inst = $urandom; in_tag = tc;
        checks++;
        if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got %b/%b exp 0", in_ready32, in_ready64);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_tag32 !== ta || out_imm32 !== ea.imm32 || out_imm64 !== ea.imm64
            || in_ready32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_stable got tag %h imm %h rdy %b exp %h %h 0",
                     out_tag32, out_imm32, in_ready32, ta, ea.imm32);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid32 !== 1'b1 || out_tag32 !== tb) begin
            errors++;
            $display("FAIL bp_second got v %b tag %h exp 1 %h",
                     out_valid32, out_tag32, tb);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_third_dropped got v %b tag %h exp v 0",
                     out_valid32, out_tag32);
        end
        idle();
    endtask

    task automatic test_push_pop();
        logic [31:0] tags[$];
        tags.push_back($urandom);
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b0; in_type = 3'd2;
        in_inst = $urandom; in_tag = tags[0];
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid32 !== 1'b1 || in_ready32 !== 1'b1
                || out_tag32 !== tags[k-1]) begin
                errors++;
                $display("FAIL pushpop[%0d] got v %b rdy %b tag %h exp 1 1 %h",
                         k, out_valid32, in_ready32, out_tag32, tags[k-1]);
            end
            tags.push_back($urandom);
            in_valid = 1'b1; out_ready = 1'b1;
            in_inst = $urandom; in_tag = tags[k];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b1 || out_tag32 !== tags[8]) begin
            errors++;
            $display("FAIL pushpop_last got v %b tag %h exp 1 %h",
                     out_valid32, out_tag32, tags[8]);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++; $display("FAIL pushpop_drain got v %b exp 0", out_valid32);
        end
        idle();
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b0; in_type = 3'd1;
        in_inst = $urandom; in_tag = 32'hA;
        @(posedge clk); #1;
        in_tag = 32'hB;
        @(posedge clk); #1;
        flush = 1'b1; in_tag = 32'hC;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL flush_full got v %b rdy %b exp 0 1", out_valid32, in_ready32);
        end
        in_valid = 1'b1; in_tag = 32'hD;
        @(posedge clk); #1;
        flush = 1'b1; in_tag = 32'hE;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_accept got v %b tag %h exp v 0",
                     out_valid32, out_tag32);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got v %b tag %h exp v 0", out_valid32, out_tag32);
        end
        idle();
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b0; in_type = 3'd1;
        in_inst = 32'hFFF00093; in_tag = 32'hDEAD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL arst_pre got v %b imm %h exp 1 ffffffff",
                     out_valid32, out_imm32);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid32 !== 1'b0 || out_imm32 !== 32'h0 || out_imm64 !== 64'h0
            || out_tag32 !== 32'h0 || out_valid64 !== 1'b0) begin
            errors++;
            $display("FAIL arst_now got v %b imm %h/%h tag %h exp 0",
                     out_valid32, out_imm32, out_imm64, out_tag32);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            errors++;
            $display("FAIL arst_after got v %b rdy %b exp 0 1", out_valid32, in_ready32);
        end
        idle();
    endtask

    task automatic test_random();
        exp_t q[$];
        logic hold = 1'b0;
        logic [31:0] p_imm, p_tag;
        logic [63:0] p_imm64;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (hold) begin
                checks++;
                if (out_imm32 !== p_imm || out_imm64 !== p_imm64 || out_tag32 !== p_tag) begin
                    errors++;
                    $display("FAIL rnd_stable[%0d] got %h tag %h exp %h tag %h",
                             n, out_imm32, out_tag32, p_imm, p_tag);
                end
            end
            checks++;
            if (out_valid32 !== (q.size() != 0) || in_ready32 !== (q.size() < 2)
                || out_valid64 !== out_valid32 || in_ready64 !== in_ready32) begin
                errors++;
                $display("FAIL rnd_hs[%0d] got v %b rdy %b exp count %0d",
                         n, out_valid32, in_ready32, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (out_imm32 !== q[0].imm32 || out_imm64 !== q[0].imm64
                    || out_err32 !== q[0].err32 || out_err64 !== 1'b0
                    || out_tag32 !== q[0].tag || out_tag64 !== q[0].tag) begin
                    errors++;
                    $display("FAIL rnd_data[%0d] got %h/%h err %b tag %h exp %h/%h err %b tag %h",
                             n, out_imm32, out_imm64, out_err32, out_tag32,
                             q[0].imm32, q[0].imm64, q[0].err32, q[0].tag);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_inst   = $urandom;
            in_type   = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            hold    = (q.size() != 0) && !out_ready && !flush;
            p_imm   = out_imm32;
            p_imm64 = out_imm64;
            p_tag   = out_tag32;
            if (flush) begin
                q.delete();
            end else begin
                logic acc;
                acc = in_valid && (q.size() < 2);
                if (out_ready && q.size() != 0) void'(q.pop_front());
                if (acc) q.push_back(mk_exp(in_inst, in_type, in_tag));
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_async_reset();
        test_random();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
